fringe_synthesizer: RTL and testbench

- Generates a synthetic interferometer sample stream from a commanded target position. Each one-count position step is encoded as one full fringe: a ramp from the low level up to the high level, then back down to the low level.
- Used to stimulate the fringe-counting position decode path in loopback or self-test. It also serves as a bench stimulus source for that path.
- Target positions arrive on an AXI-Stream slave. Samples leave on an AXI-Stream master with backpressure.

---
 rtl/fringe_synthesizer.sv | 152 +++++++++++++++
 tb/tb_fringe_synthesizer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fringe_synthesizer.sv
// Synthetic interferometer source: every one-count step toward the commanded
// target is emitted as a full fringe, low -> high -> low, on an AXI-Stream master.
module fringe_synthesizer #(
    parameter int unsigned AXIS_TDATA_WIDTH = 32
) (
    input  logic                        SYS_aclk,
    input  logic                        SYS_areset,
    input  logic                        FC_enable,
    input  logic [AXIS_TDATA_WIDTH-1:0] FC_low_level,
    input  logic [AXIS_TDATA_WIDTH-1:0] FC_high_level,
    input  logic [AXIS_TDATA_WIDTH-1:0] FC_step,
    input  logic                        S_AXIS_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    output logic                        S_AXIS_tready,
    output logic                        M_AXIS_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    input  logic                        M_AXIS_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] ST_position,
    output logic                        ST_sign,
    output logic                        ST_busy
);

    localparam int unsigned W  = AXIS_TDATA_WIDTH;
    localparam int unsigned XW = AXIS_TDATA_WIDTH + 2;
    localparam logic [W-1:0] ONE = W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   sample_q, sample_d;
    logic [W-1:0]   position_q, position_d;
    logic [W-1:0]   target_q, target_d;
    logic           sign_q, sign_d;
    logic           m_valid_q;

    logic           cfg_valid;
    logic           beat;
    logic           s_hs;
    logic [W-1:0]   step_eff;
    logic [W-1:0]   position_step;
    logic signed [XW-1:0] sample_x, low_x, high_x, step_x, up_x, dn_x;
    logic [W-1:0]   rise_val, fall_val;

    assign cfg_valid     = $signed(FC_high_level) > $signed(FC_low_level);
    assign S_AXIS_tready = (state_q == IDLE) & FC_enable & cfg_valid & m_valid_q;
    assign s_hs          = S_AXIS_tvalid & S_AXIS_tready;
    assign beat          = m_valid_q & M_AXIS_tready;
    assign step_eff      = (FC_step == '0) ? ONE : FC_step;
    assign position_step = sign_q ? position_q + ONE : position_q - ONE;

    assign M_AXIS_tvalid = m_valid_q;
    assign M_AXIS_tdata  = sample_q;
    assign ST_position   = position_q;
    assign ST_sign       = sign_q;
    assign ST_busy       = (state_q != IDLE);

    // Ramp arithmetic: two guard bits so an unsigned step added to any signed
    // sample cannot wrap; results are clamped to [low, high] in both directions
    // so a mid-fringe level change pulls an out-of-range sample back in.
    always_comb begin
        sample_x = $signed({{2{sample_q[W-1]}}, sample_q});
        low_x    = $signed({{2{FC_low_level[W-1]}}, FC_low_level});
        high_x   = $signed({{2{FC_high_level[W-1]}}, FC_high_level});
        step_x   = $signed({2'b00, step_eff});
        up_x     = sample_x + step_x;
        dn_x     = sample_x - step_x;
        rise_val = up_x[W-1:0];
        fall_val = dn_x[W-1:0];
        if (up_x >= high_x) begin
            rise_val = FC_high_level;
        end else if (up_x <= low_x) begin
            rise_val = FC_low_level;
        end
        if (dn_x <= low_x) begin
            fall_val = FC_low_level;
        end else if (dn_x >= high_x) begin
            fall_val = FC_high_level;
        end
    end

    // Next-state, sample, position and target decode.
    always_comb begin
        state_d    = state_q;
        sample_d   = sample_q;
        position_d = position_q;
        target_d   = target_q;
        sign_d     = sign_q;
        case (state_q)
            IDLE: begin
                sample_d = FC_low_level;
                if (s_hs) begin
                    target_d = S_AXIS_tdata;
                    if (S_AXIS_tdata != position_q) begin
                        sign_d  = $signed(S_AXIS_tdata) > $signed(position_q);
                        state_d = RISE;
                    end
                end
            end
            RISE: begin
                if (!(FC_enable && cfg_valid)) begin
                    state_d  = IDLE;
                    sample_d = FC_low_level;
                end else if (beat) begin
                    sample_d = rise_val;
                    if (rise_val == FC_high_level) begin
                        state_d = FALL;
                    end
                end
            end
            FALL: begin
                if (!(FC_enable && cfg_valid)) begin
                    state_d  = IDLE;
                    sample_d = FC_low_level;
                end else if (beat) begin
                    sample_d = fall_val;
                    if (fall_val == FC_low_level) begin
                        position_d = position_step;
                        state_d    = (position_step == target_q) ? IDLE : RISE;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                sample_d = FC_low_level;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge SYS_aclk or posedge SYS_areset) begin
        if (SYS_areset) begin
            state_q    <= IDLE;
            sample_q   <= '0;
            position_q <= '0;
            target_q   <= '0;
            sign_q     <= 1'b1;
            m_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sample_q   <= sample_d;
            position_q <= position_d;
            target_q   <= target_d;
            sign_q     <= sign_d;
            m_valid_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fringe_synthesizer.sv
// Scoreboard bench for fringe_synthesizer: expected samples/positions are
// generated when a target is sent and compared on each ramp beat.
module tb_fringe_synthesizer;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst;
    logic         en;
    logic [W-1:0] lo, hi, st;
    logic         s_valid;
    logic [W-1:0] s_data;
    logic         s_ready;
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_ready;
    logic [W-1:0] pos;
    logic         sign;
    logic         busy;

    typedef struct {
        longint sample;
        longint position;
    } exp_t;

    exp_t   exp_q[$];
    longint model_pos;
    int     n_checks;
    int     n_errors;
    int     beat_count;

    fringe_synthesizer #(.AXIS_TDATA_WIDTH(W)) dut (
        .SYS_aclk      (clk),
        .SYS_areset    (rst),
        .FC_enable     (en),
        .FC_low_level  (lo),
        .FC_high_level (hi),
        .FC_step       (st),
        .S_AXIS_tvalid (s_valid),
        .S_AXIS_tdata  (s_data),
        .S_AXIS_tready (s_ready),
        .M_AXIS_tvalid (m_valid),
        .M_AXIS_tdata  (m_data),
        .M_AXIS_tready (m_ready),
        .ST_position   (pos),
        .ST_sign       (sign),
        .ST_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Push n fringes starting from low level, tracking model position.
    task automatic push_fringes(input int n, input longint l, input longint h,
                                input longint stp, input bit up);
        longint s;
        exp_t   e;
        longint k;
        k = (stp == 0) ? 1 : stp;
        s = l;
        for (int f = 0; f < n; f++) begin
            do begin
                s = (s + k > h) ? h : s + k;
                e.sample = s; e.position = model_pos;
                exp_q.push_back(e);
            end while (s != h);
            do begin
                s = (s - k < l) ? l : s - k;
                if (s == l) model_pos = up ? model_pos + 1 : model_pos - 1;
                e.sample = s; e.position = model_pos;
                exp_q.push_back(e);
            end while (s != l);
        end
    endtask

    task automatic send_target(input int t);
        bit hs;
        hs = 1'b0;
        s_valid = 1'b1;
        s_data  = t;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_ready) begin
                hs = 1'b1;
                break;
            end
        end
        check("handshake", hs, 1);
        @(posedge clk); #2;
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #2;
        end
        check("idle_reached", done, 1);
    endtask

    // Ramp-beat monitor: a beat that the DUT will act on is compared just
    // after the edge that consumes it.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready && busy && en && ($signed(hi) > $signed(lo))) begin
            @(posedge clk); #1;
            beat_count++;
            if (exp_q.size() == 0) begin
                check("extra_beat", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sample", longint'($signed(m_data)), e.sample);
                check("position", longint'($signed(pos)), e.position);
            end
        end
    end

    initial begin
        int     b0;
        logic [W-1:0] d;
        bit [3:0] pat;
        n_checks = 0; n_errors = 0; beat_count = 0; model_pos = 0;
        rst = 1'b1; en = 1'b0; lo = '0; hi = '0; st = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        pat = 4'b1001;

        #3;
        check("rst_tvalid", m_valid, 0);
        check("rst_sready", s_ready, 0);
        check("rst_tdata", m_data, 0);
        check("rst_position", pos, 0);
        check("rst_sign", sign, 1);
        check("rst_busy", busy, 0);

        @(posedge clk); #2;
        rst = 1'b0;
        lo = -100; hi = 100; st = 50; en = 1'b1; m_ready = 1'b1;
        @(posedge clk); #1;
        check("tvalid_up", m_valid, 1);
        check("idle_low", longint'($signed(m_data)), -100);
        check("sready_idle", s_ready, 1);
        #1;

        // Ramp up three counts.
        b0 = beat_count;
        push_fringes(3, -100, 100, 50, 1'b1);
        send_target(3);
        check("sign_up", sign, 1);
        check("busy_up", busy, 1);
        wait_idle(100);
        check("beats_up", beat_count - b0, 24);
        check("pos_up", longint'($signed(pos)), 3);
        check("sready_back", s_ready, 1);

        // Ramp down two counts.
        b0 = beat_count;
        push_fringes(2, -100, 100, 50, 1'b0);
        send_target(1);
        check("sign_down", sign, 0);
        wait_idle(100);
        check("beats_down", beat_count - b0, 16);
        check("pos_down", longint'($signed(pos)), 1);

        // Same target: no motion.
        b0 = beat_count;
        send_target(1);
        check("busy_same", busy, 0);
        repeat (4) @(posedge clk);
        #2;
        check("beats_same", beat_count - b0, 0);
        check("tdata_same", longint'($signed(m_data)), -100);

        // Clamped step with backpressure.
        st = 70;
        push_fringes(1, -100, 100, 70, 1'b1);
        send_target(2);
        for (int i = 0; i < 200 && busy; i++) begin
            m_ready = pat[i % 4];
            d = m_data;
            @(posedge clk); #2;
            if (!pat[i % 4]) check("hold_tdata", m_data, d);
        end
        m_ready = 1'b1;
        check("bp_queue_empty", exp_q.size(), 0);
        check("bp_pos", longint'($signed(pos)), 2);
        check("bp_sign", sign, 1);

        // Abort mid-RISE.
        st = 50;
        push_fringes(3, -100, 100, 50, 1'b1);
        send_target(5);
        repeat (3) @(posedge clk);
        #2;
        en = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", busy, 0);
        check("abort_tdata", longint'($signed(m_data)), -100);
        check("abort_pos", longint'($signed(pos)), 2);
        exp_q.delete();
        model_pos = 2;
        #1;
        en = 1'b1;
        push_fringes(1, -100, 100, 50, 1'b1);
        send_target(3);
        wait_idle(100);
        check("reenable_pos", longint'($signed(pos)), 3);

        // Invalid config blocks target acceptance.
        lo = 0; hi = 0;
        s_valid = 1'b1; s_data = 7;
        repeat (3) @(posedge clk);
        #2;
        check("inv_sready", s_ready, 0);
        check("inv_busy", busy, 0);
        check("inv_tdata", longint'($signed(m_data)), 0);
        check("inv_pos", longint'($signed(pos)), 3);
        hi = 100;
        push_fringes(4, 0, 100, 50, 1'b1);
        send_target(7);
        wait_idle(200);
        check("valid_pos", longint'($signed(pos)), 7);

        // Asynchronous reset mid-fringe.
        lo = -100;
        @(posedge clk); #2;
        push_fringes(2, -100, 100, 50, 1'b1);
        send_target(9);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_tvalid", m_valid, 0);
        check("arst_tdata", m_data, 0);
        check("arst_pos", pos, 0);
        check("arst_busy", busy, 0);
        check("arst_sign", sign, 1);
        check("arst_sready", s_ready, 0);
        exp_q.delete();
        model_pos = 0;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("rel_tvalid_lo", m_valid, 0);
        @(posedge clk); #1;
        check("rel_tvalid_hi", m_valid, 1);
        check("rel_sready", s_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
